// File: rtl/fluxo_dados_exp7.sv
// fluxo_dados_exp7: memory-game datapath with address/round/timeout/display counters,
// move register, resettable 16x4 move memory and button-press edge detection.
module fluxo_dados_exp7 #(
   parameter int TIMEOUT   = 5000,
   parameter int TEMPO_LED = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       zeraE,
   input  logic       contaE,
   input  logic       zeraRod,
   input  logic       contaRod,
   input  logic       zeraT,
   input  logic       contaT,
   input  logic       zeraP,
   input  logic       contaP,
   input  logic       zeraR,
   input  logic       registraR,
   input  logic       we,
   input  logic       sinal_led,
   input  logic [3:0] botoes,
   output logic       fimE,
   output logic       fimRod,
   output logic       fimT,
   output logic       fimP,
   output logic       jogada,
   output logic       igual,
   output logic       enderecoIgualRodada,
   output logic [3:0] leds,
   output logic [3:0] db_contagem,
   output logic [3:0] db_rodada,
   output logic [3:0] db_jogada,
   output logic [3:0] db_memoria
);
   localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
   localparam int PW = TEMPO_LED > 1 ? $clog2(TEMPO_LED) : 1;
   localparam logic [TW-1:0] tMax = TW'(TIMEOUT - 1);
   localparam logic [PW-1:0] pMax = PW'(TEMPO_LED - 1);
   localparam logic [63:0] memInit = 64'h4188_4422_1124_8421;

   logic [3:0] e, rod, r, memOut;
   logic [TW-1:0] t;
   logic [PW-1:0] p;
   logic prevPress, press;
   logic [3:0] mem [16];

   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         e <= '0;
         rod <= '0;
         t <= '0;
         p <= '0;
         r <= '0;
         prevPress <= 1'b0;
      end else begin
         e <= zeraE ? 4'd0 : contaE ? e + 4'd1 : e;
         rod <= zeraRod ? 4'd0 : contaRod ? rod + 4'd1 : rod;
         t <= zeraT ? '0 : (contaT && t != tMax) ? t + TW'(1) : t;
         p <= zeraP ? '0 : (contaP && p != pMax) ? p + PW'(1) : p;
         r <= zeraR ? 4'd0 : registraR ? botoes : r;
         prevPress <= press;
      end

   // Memory reloads the fixed opening sequence so every game starts identically
   always_ff @(posedge clock or posedge reset)
      if (reset)
         for (int i = 0; i < 16; i++) mem[i] <= memInit[4*i +: 4];
      else if (we)
         mem[e] <= r;

   assign press = |botoes;
   assign memOut = mem[e];
   assign fimE = e == 4'd15;
   assign fimRod = rod == 4'd15;
   assign fimT = t == tMax;
   assign fimP = p == pMax;
   assign jogada = press & ~prevPress;
   assign igual = r == memOut;
   assign enderecoIgualRodada = e == rod;
   assign leds = sinal_led ? memOut : botoes;
   assign db_contagem = e;
   assign db_rodada = rod;
   assign db_jogada = r;
   assign db_memoria = memOut;
endmodule

// File: doc/fluxo_dados_exp7.md
FLUXO_DADOS_EXP7 -- requirements
Module: fluxo_dados_exp7

Interface
REQ-001 Parameter: TIMEOUT, 5000, clock cycles allowed per player move.
REQ-002 Parameter: TEMPO_LED, 1000, clock cycles the initial move is shown on leds.
REQ-003 Port: clock  input  1  system clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high.
REQ-005 Ports: zeraE, contaE  input  1 each  address counter synchronous clear / increment.
REQ-006 Ports: zeraRod, contaRod  input  1 each  round counter clear / increment.
REQ-007 Ports: zeraT, contaT  input  1 each  timeout counter clear / increment.
REQ-008 Ports: zeraP, contaP  input  1 each  display counter clear / increment.
REQ-009 Ports: zeraR, registraR  input  1 each  move register clear / load.
REQ-010 Ports: we  input  1  memory write enable; sinal_led  input  1  show stored move on leds.
REQ-011 Port: botoes  input  4  player buttons, one-hot when valid.
REQ-012 Ports: fimE, fimRod, fimT, fimP, jogada, igual, enderecoIgualRodada  output  1 each  status to control unit.
REQ-013 Port: leds  output  4  player-visible LEDs.
REQ-014 Ports: db_contagem, db_rodada, db_jogada, db_memoria  output  4 each  debug: address counter, round counter, move register, memory read data.

Function
REQ-015 Address counter E (4 bits): zeraE -> 0; else contaE -> E+1, wraps 15->0; zeraE has priority over contaE.
REQ-016 fimE SHALL be 1 exactly when E == 15 (combinational).
REQ-017 Round counter Rod (4 bits): same priority/wrap rules as E; fimRod = 1 exactly when Rod == 15.
REQ-018 Timeout counter T: zeraT -> 0; else contaT -> T+1, saturating at TIMEOUT-1; fimT = 1 exactly when T == TIMEOUT-1.
REQ-019 Display counter P: zeraP -> 0; else contaP -> P+1, saturating at TEMPO_LED-1; fimP = 1 exactly when P == TEMPO_LED-1.
REQ-020 Move register R (4 bits): zeraR -> 0; else registraR -> R <= botoes; zeraR has priority.
REQ-021 Memory: 16 x 4, asynchronous read at address E; synchronous write of R to address E when we = 1.
REQ-022 Memory initial contents, addresses 0..15: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4 (hex).
REQ-023 igual = 1 exactly when R == mem[E] (combinational).
REQ-024 enderecoIgualRodada = 1 exactly when E == Rod (combinational).
REQ-025 Edge detector: internal flop holds previous OR(botoes); jogada = OR(botoes) AND NOT previous; exactly one-cycle pulse per press, regardless of hold length.
REQ-026 Simultaneous press of several buttons: single jogada pulse; R loads the raw multi-hot value.
REQ-027 leds = mem[E] when sinal_led = 1, else leds = botoes.
REQ-028 db_contagem = E, db_rodada = Rod, db_jogada = R, db_memoria = mem[E].
REQ-029 Write and read same address same cycle: read returns old data until the following cycle.

Reset
REQ-030 reset = 1 SHALL immediately force E, Rod, T, P, R and the edge-detector flop to 0 and restore memory to REQ-022 contents.
REQ-031 Outputs after reset with botoes = 0: fimE=0, fimRod=0, fimT=0, fimP=0, jogada=0, igual=0 (R=0, mem[0]=1), enderecoIgualRodada=1, leds=0.
REQ-032 Reset asserted mid-operation (counting, writing) SHALL abort the operation; no memory write occurs in a cycle where reset = 1.

Verification
REQ-033 Reset, then contaE for 15 cycles -> E=15, fimE=1; one more contaE -> E=0, fimE=0; zeraE+contaE same cycle -> E=0.
REQ-034 contaT held TIMEOUT+10 cycles -> fimT rises after TIMEOUT-1 increments and stays 1, T stays TIMEOUT-1; zeraT -> fimT=0 next cycle.
REQ-035 botoes=4'b0010 held 20 cycles -> jogada high exactly 1 cycle; registraR that cycle -> R=2; E=1 -> igual=1; E=0 -> igual=0.
REQ-036 R=8, E=3... set E=2, we=1 one cycle -> mem[2]=8, db_memoria=8 next cycle; reset -> mem[2]=4.
REQ-037 sinal_led=1, E=0 -> leds=4'b0001; sinal_led=0, botoes=4'b0100 -> leds=4'b0100; contaP TEMPO_LED-1 cycles -> fimP=1.
REQ-038 Rod=3, E stepped 0..3 -> enderecoIgualRodada=1 only at E=3.
